// File: rtl/ram_arbiter.sv
// Round-robin arbiter between the CPU control unit and the I/O loader for one single-port
// synchronous RAM. Every output is a flop loaded from next-state, so done/we never glitch.
module ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t              state;
  state_t              next_state;
  logic [1:0]          cnt;
  logic [1:0]          next_cnt;
  logic                last_served;  // 1 = loader was served last
  logic                we_lat;
  logic                grant;
  logic                grant_io;
  logic                capture;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  assign win_we    = grant_io ? io_we    : cpu_we;
  assign win_addr  = grant_io ? io_addr  : cpu_addr;
  assign win_wdata = grant_io ? io_wdata : cpu_wdata;

  // next-state, wait-counter and grant decode
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    grant      = 1'b0;
    grant_io   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && io_req) begin
          grant    = 1'b1;
          grant_io = ~last_served;
        end else if (cpu_req) begin
          grant    = 1'b1;
          grant_io = 1'b0;
        end else if (io_req) begin
          grant    = 1'b1;
          grant_io = 1'b1;
        end else begin
          grant    = 1'b0;
          grant_io = 1'b0;
        end
        if (grant) begin
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: begin
        if (we_lat) begin
          next_state = DONE;
        end else begin
          next_cnt   = WAIT_INIT;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          capture    = 1'b1;
          next_state = DONE;
        end else begin
          next_cnt   = cnt - 2'd1;
          next_state = WAIT;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // state, counter and arbitration history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      last_served <= 1'b1;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (grant) begin
        last_served <= grant_io;
      end
    end
  end

  // latched transaction fields and RAM-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_lat    <= 1'b0;
      owner     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      rdata     <= '0;
    end else begin
      if (grant) begin
        we_lat    <= win_we;
        owner     <= grant_io;
        ram_addr  <= win_addr;
        ram_wdata <= win_wdata;
      end
      // high only for the single ISSUE cycle
      ram_we <= grant & win_we;
      if (capture) begin
        rdata <= ram_q;
      end
    end
  end

  // requester-side status, registered from next-state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_done <= 1'b0;
      io_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cpu_done <= (next_state == DONE) && !owner;
      io_done  <= (next_state == DONE) && owner;
      busy     <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RD_LAT 1 and 3) with latency-accurate RAM models,
// a transaction-timeline reference model checked every cycle, plus directed scenarios.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  logic cpu_req [2];
  logic cpu_we  [2];
  logic io_req  [2];
  logic io_we   [2];
  logic [AW-1:0] cpu_addr [2];
  logic [AW-1:0] io_addr  [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] cpu_wdata [2];
  logic [DW-1:0] io_wdata  [2];
  logic [DW-1:0] rdata     [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] ram_q     [2];
  logic cpu_done [2];
  logic io_done  [2];
  logic ram_we   [2];
  logic busy     [2];
  logic owner    [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_done(cpu_done[0]),
    .io_req(io_req[0]), .io_we(io_we[0]), .io_addr(io_addr[0]), .io_wdata(io_wdata[0]),
    .io_done(io_done[0]),
    .rdata(rdata[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_we(ram_we[0]),
    .ram_q(ram_q[0]), .busy(busy[0]), .owner(owner[0])
  );

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_done(cpu_done[1]),
    .io_req(io_req[1]), .io_we(io_we[1]), .io_addr(io_addr[1]), .io_wdata(io_wdata[1]),
    .io_done(io_done[1]),
    .rdata(rdata[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_we(ram_we[1]),
    .ram_q(ram_q[1]), .busy(busy[1]), .owner(owner[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a, ~a} ^ 16'h5A5A;
  endfunction

  // RAM models: q appears RD_LAT cycles after the address is presented
  logic [DW-1:0] mem [2][256];
  logic [DW-1:0] qp  [2][3];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (init_mem) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= init_val(8'(a));
      end else if (ram_we[k]) begin
        mem[k][ram_addr[k]] <= ram_wdata[k];
      end
      qp[k][0] <= mem[k][ram_addr[k]];
      qp[k][1] <= qp[k][0];
      qp[k][2] <= qp[k][1];
    end
  end
  assign ram_q[0] = qp[0][0];
  assign ram_q[1] = qp[1][2];

  // reference model: each transaction is a timeline (granted at t, issue t+1, done m_d)
  bit            m_act  [2];
  int            m_t    [2];
  int            m_d    [2];
  logic          m_own  [2];
  logic          m_we   [2];
  logic          m_last [2];
  logic [7:0]    m_addr [2];
  logic [15:0]   m_wd   [2];
  logic [15:0]   m_rd   [2];
  logic [15:0]   gm     [2][256];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_t[k] = 0; m_d[k] = 0; m_own[k] = 1'b0; m_we[k] = 1'b0;
      m_last[k] = 1'b1; m_addr[k] = 8'h00; m_wd[k] = 16'h0000; m_rd[k] = 16'h0000;
    end
  endtask

  task automatic model_step(input int k, input int e);
    bit g;
    bit gi;
    if (m_act[k] && m_we[k] && e == m_t[k] + 2) gm[k][m_addr[k]] = m_wd[k];
    if (m_act[k] && !m_we[k] && e == m_d[k]) m_rd[k] = gm[k][m_addr[k]];
    if (!m_act[k] || (e - 1 > m_d[k])) begin
      g  = cpu_req[k] | io_req[k];
      gi = (cpu_req[k] && io_req[k]) ? !m_last[k] : io_req[k];
      if (g) begin
        m_act[k]  = 1'b1;
        m_t[k]    = e - 1;
        m_own[k]  = gi;
        m_last[k] = gi;
        m_we[k]   = gi ? io_we[k] : cpu_we[k];
        m_addr[k] = gi ? io_addr[k] : cpu_addr[k];
        m_wd[k]   = gi ? io_wdata[k] : cpu_wdata[k];
        m_d[k]    = e - 1 + (m_we[k] ? 2 : 2 + lat(k));
      end
    end
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) gm[k][a] = init_val(8'(a));
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k, cyc);
    end
  end

  initial forever begin
    @(posedge rst);
    model_reset();
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", nm, k, cyc, act, exp);
    end
  endtask

  // per-cycle compare against the model, plus event monitors for directed checks
  int we_cnt [2];
  int we_cyc [2];
  logic [7:0]  we_a [2];
  logic [15:0] we_d [2];
  int io_done_cnt0 = 0;
  int dlog [$];
  initial begin
    we_cnt[0] = 0; we_cnt[1] = 0; we_cyc[0] = 0; we_cyc[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("busy",     k, 32'(busy[k]),     32'(m_act[k] && cyc >= m_t[k] + 1 && cyc <= m_d[k]));
        chk("ram_we",   k, 32'(ram_we[k]),   32'(m_act[k] && m_we[k] && cyc == m_t[k] + 1));
        chk("cpu_done", k, 32'(cpu_done[k]), 32'(m_act[k] && cyc == m_d[k] && !m_own[k]));
        chk("io_done",  k, 32'(io_done[k]),  32'(m_act[k] && cyc == m_d[k] && m_own[k]));
        chk("rdata",    k, 32'(rdata[k]),    32'(m_rd[k]));
        chk("ram_addr", k, 32'(ram_addr[k]), 32'(m_addr[k]));
        chk("ram_wdata",k, 32'(ram_wdata[k]),32'(m_wd[k]));
        chk("owner",    k, 32'(owner[k]),    32'(m_own[k]));
        chk("both_done",k, 32'(cpu_done[k] & io_done[k]), 32'd0);
        if (ram_we[k] === 1'b1) begin
          we_cnt[k]++; we_cyc[k] = cyc; we_a[k] = ram_addr[k]; we_d[k] = ram_wdata[k];
        end
      end
      if (cpu_done[0] === 1'b1) dlog.push_back(0);
      if (io_done[0] === 1'b1) begin dlog.push_back(1); io_done_cnt0++; end
    end
  end

  // one access under the requester protocol; call and return at posedge+2
  task automatic do_req(input int k, input bit io, input bit we, input logic [7:0] a,
                        input logic [15:0] d, output int t_set, output int t_done);
    if (io) begin io_req[k] = 1'b1; io_we[k] = we; io_addr[k] = a; io_wdata[k] = d; end
    else begin cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d; end
    t_set  = cyc;
    t_done = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((io ? io_done[k] : cpu_done[k]) === 1'b1) begin
        t_done = cyc;
        break;
      end
    end
    if (t_done < 0) begin
      tests++; fails++;
      $display("FAIL done_timeout[%0d] io=%0d got=none exp=done", k, io);
    end
    @(posedge clk); #2;
    if (io) io_req[k] = 1'b0; else cpu_req[k] = 1'b0;
  endtask

  task automatic rand_agent(input int k, input bit io, input int n_tr);
    int ts, td, gap;
    for (int n = 0; n < n_tr; n++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #2; end
      do_req(k, io, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom), ts, td);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts, td, ts2, td2, a1, b1, a2, b2, w0, i0;
    rst = 1'b1; init_mem = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = 8'h00; cpu_wdata[k] = 16'h0000;
      io_req[k]  = 1'b0; io_we[k]  = 1'b0; io_addr[k]  = 8'h00; io_wdata[k]  = 16'h0000;
    end
    repeat (3) @(posedge clk); #2;
    rst = 1'b0; init_mem = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, 32'(busy[k]), 32'd0);
      chk("rst_rdata", k, 32'(rdata[k]), 32'd0);
      chk("rst_owner", k, 32'(owner[k]), 32'd0);
      chk("rst_ram_addr", k, 32'(ram_addr[k]), 32'd0);
    end
    @(posedge clk); #2;

    // CPU write then loader read, RD_LAT = 1
    w0 = we_cnt[0]; i0 = io_done_cnt0;
    do_req(0, 1'b0, 1'b1, 8'h10, 16'hBEEF, ts, td);
    chk("wr_done_lat", 0, 32'(td - ts), 32'd2);
    chk("wr_we_pulses", 0, 32'(we_cnt[0] - w0), 32'd1);
    chk("wr_we_addr", 0, 32'(we_a[0]), 32'h10);
    chk("wr_we_data", 0, 32'(we_d[0]), 32'hBEEF);
    chk("wr_io_quiet", 0, 32'(io_done_cnt0 - i0), 32'd0);
    do_req(0, 1'b1, 1'b0, 8'h10, 16'h0000, ts, td);
    chk("rd_done_lat1", 0, 32'(td - ts), 32'd3);
    chk("rd_data1", 0, 32'(rdata[0]), 32'hBEEF);
    repeat (4) @(posedge clk); #2;
    chk("rd_hold1", 0, 32'(rdata[0]), 32'hBEEF);

    // same at RD_LAT = 3
    do_req(1, 1'b0, 1'b1, 8'h10, 16'hBEEF, ts, td);
    do_req(1, 1'b1, 1'b0, 8'h10, 16'h0000, ts, td);
    chk("rd_done_lat3", 1, 32'(td - ts), 32'd5);
    chk("rd_data3", 1, 32'(rdata[1]), 32'hBEEF);

    // tie with both requests held over two accesses each
    dlog.delete();
    fork
      begin
        do_req(0, 1'b0, 1'b1, 8'h30, 16'h1111, a1, b1);
        do_req(0, 1'b0, 1'b1, 8'h31, 16'h2222, a1, b1);
      end
      begin
        do_req(0, 1'b1, 1'b1, 8'h40, 16'h3333, a2, b2);
        do_req(0, 1'b1, 1'b1, 8'h41, 16'h4444, a2, b2);
      end
    join
    chk("tie_count", 0, 32'(dlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < dlog.size(); i++) chk("tie_order", 0, 32'(dlog[i]), 32'(i % 2));

    // loader arrives while a CPU read is in WAIT
    fork
      do_req(1, 1'b0, 1'b0, 8'h10, 16'h0000, ts, td);
      begin
        repeat (3) @(posedge clk); #2;
        do_req(1, 1'b1, 1'b1, 8'h50, 16'h5555, ts2, td2);
      end
    join
    chk("wait_io_issue", 1, 32'(we_cyc[1] - td), 32'd2);
    chk("wait_io_done", 1, 32'(td2 - td), 32'd3);
    chk("wait_rdata", 1, 32'(rdata[1]), 32'hBEEF);

    // reset while a write is in ISSUE
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 8'h20; cpu_wdata[0] = 16'hDEAD;
    @(posedge clk); #2;
    chk("pre_rst_we", 0, 32'(ram_we[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_we", 0, 32'(ram_we[0]), 32'd0);
    chk("arst_busy", 0, 32'(busy[0]), 32'd0);
    chk("arst_cpu_done", 0, 32'(cpu_done[0]), 32'd0);
    chk("arst_io_done", 0, 32'(io_done[0]), 32'd0);
    cpu_req[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk); #2;
    chk("post_rst_idle", 0, 32'(busy[0]), 32'd0);
    dlog.delete();
    fork
      do_req(0, 1'b0, 1'b0, 8'h20, 16'h0000, a1, b1);
      do_req(0, 1'b1, 1'b0, 8'h10, 16'h0000, a2, b2);
    join
    chk("rst_tie_first", 0, 32'(dlog.size() > 0 ? dlog[0] : 9), 32'd0);
    do_req(0, 1'b0, 1'b0, 8'h20, 16'h0000, ts, td);
    chk("aborted_write", 0, 32'(rdata[0]), 32'(init_val(8'h20)));

    // randomized traffic on both instances
    fork
      rand_agent(0, 1'b0, 40);
      rand_agent(0, 1'b1, 40);
      rand_agent(1, 1'b0, 40);
      rand_agent(1, 1'b1, 40);
    join
    repeat (5) @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter for the single-port synchronous RAM. The CPU control unit (instruction/data fetch) and the I/O program loader each issue one read or write at a time. The block grants access round-robin, drives the RAM address/data/write-enable, waits out the RAM read latency, and returns a one-cycle done pulse with read data to the winning requester. It sits between both requesters and the RAM instance on the top-level datapath.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 16, data width
- RD_LAT, 1, RAM read latency in cycles (legal 1..3)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_done  out  1  one-cycle completion pulse to CPU
- io_req, io_we, io_addr, io_wdata  in  1/1/ADDR_W/DATA_W  loader request, same semantics as cpu_*
- io_done  out  1  one-cycle completion pulse to loader
- rdata  out  DATA_W  read data; valid in the done cycle of a read, held until the next read capture
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data, valid RD_LAT cycles after the address is presented
- busy  out  1  high whenever state != IDLE
- owner  out  1  0 = CPU, 1 = loader; owner of the current or last transaction

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that was not served last.
  - On grant: latch owner, we, addr and wdata from the winner; update last_served; go to ISSUE.
- ISSUE:
  - ram_addr and ram_wdata come from the latched values.
  - ram_we = latched we, asserted in this cycle only.
  - Write: go to DONE.
  - Read: load the wait counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - ram_addr is held and ram_we = 0.
  - The counter decrements each cycle.
  - At counter = 0, capture ram_q into rdata and go to DONE.
- DONE:
  - Assert cpu_done or io_done according to owner; exactly one of them is high.
  - Go to IDLE.
- Requester protocol:
  - Hold req and all fields stable from assertion through the done cycle.
  - Deassert req in the cycle after done unless another access is wanted.
  - A req seen high in IDLE is always a new request.
- Req dropped mid-transaction: ignored; the transaction completes and done still pulses.
- A write never modifies rdata.
- Outside ISSUE/WAIT, ram_addr and ram_wdata hold their last latched values and ram_we = 0.
- Fairness: with both reqs continuously high, grants alternate CPU, loader, CPU, …

## Timing
- Reset values (asynchronous):
  - state = IDLE, counter = 0.
  - All outputs 0: cpu_done, io_done, rdata, ram_addr, ram_wdata, ram_we, busy, owner.
  - last_served = loader, so the CPU wins the first tie.
- Reset mid-transaction: ram_we drops immediately, no done pulse is issued, and the pending access is lost.
- Request sampled in IDLE at cycle t:
  - ISSUE at t+1.
  - Write done at t+2. The RAM write happens on the edge ending t+1.
  - Read done at t+2+RD_LAT.
- Back-to-back throughput per requester: write every 3 cycles, read every RD_LAT+3 cycles.
- busy is high from ISSUE through DONE inclusive.
- done and ram_we are decoded from registered state and are glitch-free per cycle.

## Test plan
- Reset, then RD_LAT=1; write 16'hBEEF to 8'h10 by the CPU:
  - ram_we high exactly one cycle with ram_addr=8'h10 and ram_wdata=16'hBEEF.
  - cpu_done at t+2; io_done stays 0.
- Loader reads 8'h10 with the RAM model at RD_LAT=1 and 3:
  - io_done at t+3 and t+5 respectively, with rdata=16'hBEEF in the done cycle.
  - rdata stays 16'hBEEF afterwards.
- Both requesters assert req in the same cycle after reset:
  - CPU is served first, then the loader.
  - With both reqs held, four transactions show done order CPU, IO, CPU, IO.
- CPU read in progress (state WAIT); the loader asserts req:
  - Loader waits; its ISSUE occurs the cycle after the CPU's DONE→IDLE.
  - cpu_done and io_done are never high together.
- Assert rst during ISSUE of a write:
  - ram_we, busy and both done signals go 0 asynchronously.
  - After release with no reqs, the block stays IDLE.
  - The next tie is granted to the CPU.
